pwd_candidate_gen: RTL and testbench

Brute-force password candidate generator that sits directly upstream of the md4 hashing core. It enumerates every string over a contiguous character range, from a start length up to MAX_LEN, in odometer order. Each candidate is streamed one byte per handshake, with its length presented on a side port that feeds md4's input_size. A 32-bit candidate counter lets the downstream comparator report which candidate index matched.

---
 rtl/pwd_candidate_gen_if.sv | 28 ++
 rtl/pwd_candidate_gen.sv | 176 +++++++++++++++++
 tb/tb_pwd_candidate_gen.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pwd_candidate_gen_if.sv
// Byte-stream link from the candidate generator to the md4 core.
// Carries the byte handshake and the per-candidate length and index sidebands.
interface pwd_candidate_gen_if;
   logic [7:0]  byte_out;
   logic        byte_valid;
   logic        byte_last;
   logic        byte_ready;
   logic [7:0]  cand_len;
   logic [31:0] cand_count;

   modport master (
      output byte_out,
      output byte_valid,
      output byte_last,
      output cand_len,
      output cand_count,
      input  byte_ready
   );

   modport slave (
      input  byte_out,
      input  byte_valid,
      input  byte_last,
      input  cand_len,
      input  cand_count,
      output byte_ready
   );
endinterface

// File: rtl/pwd_candidate_gen.sv
// Brute-force password candidate generator: odometer enumeration over
// [CHAR_FIRST..CHAR_LAST], lengths init_len..MAX_LEN, streamed one byte per handshake.
module pwd_candidate_gen #(
   parameter int         MAX_LEN    = 8,
   parameter logic [7:0] CHAR_FIRST = 8'h61,
   parameter logic [7:0] CHAR_LAST  = 8'h7a
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic                       stop,
   input  logic [7:0]                 init_len,
   pwd_candidate_gen_if.master        bus,
   output logic                       busy,
   output logic                       exhausted
);
   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_STREAM  = 2'd1;
   localparam logic [1:0] S_ADVANCE = 2'd2;
   localparam logic [1:0] S_DONE    = 2'd3;
   localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

   logic [1:0]         state_q, state_d;
   logic [7:0]         len_q, len_d;
   logic [7:0]         idx_q, idx_d;
   logic [31:0]        count_q, count_d;
   logic               exhausted_q, exhausted_d;
   logic [7:0]         char_q [MAX_LEN];
   logic [7:0]         char_d [MAX_LEN];
   logic [7:0]         adv_char [MAX_LEN];
   logic [MAX_LEN-1:0] pos_active;
   logic [MAX_LEN-1:0] pos_at_last;
   logic               carry_out;
   logic [7:0]         clamp_len;
   logic [7:0]         cur_byte;
   logic               streaming;
   logic               at_last_byte;
   logic               handshake;

   // Per-position flags: only positions below len take part in the odometer.
   generate
      for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_pos
         assign pos_active[gi]  = (8'(gi) < len_q);
         assign pos_at_last[gi] = (char_q[gi] == CHAR_LAST);
      end
   endgenerate

   always_comb begin
      logic carry;
      carry = 1'b1;
      for (int i = MAX_LEN - 1; i >= 0; i--) begin
         adv_char[i] = char_q[i];
         if (pos_active[i] && carry) begin
            if (pos_at_last[i]) begin
               adv_char[i] = CHAR_FIRST;
            end else begin
               adv_char[i] = char_q[i] + 8'd1;
               carry       = 1'b0;
            end
         end
      end
      carry_out = carry;
   end

   always_comb begin
      cur_byte = 8'd0;
      for (int i = 0; i < MAX_LEN; i++) begin
         if (idx_q == 8'(i)) begin
            cur_byte = char_q[i];
         end
      end
   end

   always_comb begin
      if (init_len == 8'd0) begin
         clamp_len = 8'd1;
      end else if (init_len > MAX_LEN_B) begin
         clamp_len = MAX_LEN_B;
      end else begin
         clamp_len = init_len;
      end
   end

   assign streaming    = (state_q == S_STREAM);
   assign at_last_byte = (idx_q == len_q - 8'd1);
   assign handshake    = streaming && bus.byte_ready;

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      idx_d       = idx_q;
      count_d     = count_q;
      exhausted_d = exhausted_q;
      for (int i = 0; i < MAX_LEN; i++) begin
         char_d[i] = char_q[i];
      end

      case (state_q)
         S_IDLE, S_DONE: begin
            // stop outranks start; from DONE it drops to IDLE keeping exhausted
            if (stop) begin
               state_d = S_IDLE;
            end else if (start) begin
               len_d       = clamp_len;
               idx_d       = 8'd0;
               count_d     = 32'd0;
               exhausted_d = 1'b0;
               state_d     = S_STREAM;
               for (int i = 0; i < MAX_LEN; i++) begin
                  char_d[i] = CHAR_FIRST;
               end
            end
         end
         S_STREAM: begin
            if (stop) begin
               state_d = S_IDLE;
            end else if (handshake) begin
               if (at_last_byte) begin
                  idx_d   = 8'd0;
                  state_d = S_ADVANCE;
               end else begin
                  idx_d = idx_q + 8'd1;
               end
            end
         end
         S_ADVANCE: begin
            if (stop) begin
               state_d = S_IDLE;
            end else if (carry_out && (len_q == MAX_LEN_B)) begin
               exhausted_d = 1'b1;
               state_d     = S_DONE;
            end else begin
               count_d = count_q + 32'd1;
               state_d = S_STREAM;
               if (carry_out) begin
                  len_d = len_q + 8'd1;
               end
               for (int i = 0; i < MAX_LEN; i++) begin
                  char_d[i] = carry_out ? CHAR_FIRST : adv_char[i];
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         len_q       <= 8'd0;
         idx_q       <= 8'd0;
         count_q     <= 32'd0;
         exhausted_q <= 1'b0;
         for (int i = 0; i < MAX_LEN; i++) begin
            char_q[i] <= CHAR_FIRST;
         end
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         idx_q       <= idx_d;
         count_q     <= count_d;
         exhausted_q <= exhausted_d;
         for (int i = 0; i < MAX_LEN; i++) begin
            char_q[i] <= char_d[i];
         end
      end
   end

   assign bus.byte_valid = streaming;
   assign bus.byte_out   = streaming ? cur_byte : 8'd0;
   assign bus.byte_last  = streaming && at_last_byte;
   assign bus.cand_len   = len_q;
   assign bus.cand_count = count_q;
   assign busy           = (state_q == S_STREAM) || (state_q == S_ADVANCE);
   assign exhausted      = exhausted_q;
endmodule

// File: tb/tb_pwd_candidate_gen.sv
// Scoreboard bench for pwd_candidate_gen: three configurations, expected bytes
// queued at stimulus time and checked by per-instance handshake monitors.
module tb_pwd_candidate_gen;
   logic clk;
   logic reset_n;
   logic start_a, stop_a, start_b, stop_b, start_c, stop_c;
   logic [7:0] init_a, init_b, init_c;
   logic busy_a, busy_b, busy_c, exh_a, exh_b, exh_c;

   int n_vec = 0;
   int n_err = 0;

   logic [48:0] q_a[$];
   logic [48:0] q_b[$];
   logic [48:0] q_c[$];

   pwd_candidate_gen_if bus_a ();
   pwd_candidate_gen_if bus_b ();
   pwd_candidate_gen_if bus_c ();

   pwd_candidate_gen #(.MAX_LEN(2), .CHAR_FIRST(8'h61), .CHAR_LAST(8'h63)) u_a (
      .clk(clk), .reset(reset_n), .start(start_a), .stop(stop_a), .init_len(init_a),
      .bus(bus_a.master), .busy(busy_a), .exhausted(exh_a));

   pwd_candidate_gen #(.MAX_LEN(8), .CHAR_FIRST(8'h61), .CHAR_LAST(8'h7a)) u_b (
      .clk(clk), .reset(reset_n), .start(start_b), .stop(stop_b), .init_len(init_b),
      .bus(bus_b.master), .busy(busy_b), .exhausted(exh_b));

   pwd_candidate_gen #(.MAX_LEN(3), .CHAR_FIRST(8'h78), .CHAR_LAST(8'h78)) u_c (
      .clk(clk), .reset(reset_n), .start(start_c), .stop(stop_c), .init_len(init_c),
      .bus(bus_c.master), .busy(busy_c), .exhausted(exh_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Base-nchr counting model: candidate j of length L, digit p (p=0 most significant).
   task automatic push_seq(input int which, input int maxl, input int nchr,
                           input logic [7:0] first, input int init, input int nbytes);
      int  l0;
      int  pushed;
      int  cnt;
      logic [48:0] e;
      l0 = (init == 0) ? 1 : ((init > maxl) ? maxl : init);
      pushed = 0;
      cnt = 0;
      for (int l = l0; l <= maxl; l++) begin
         longint total;
         total = 1;
         for (int k = 0; k < l; k++) total = total * nchr;
         for (longint j = 0; j < total; j++) begin
            for (int p = 0; p < l; p++) begin
               longint w;
               logic [7:0] b;
               w = 1;
               for (int k = p + 1; k < l; k++) w = w * nchr;
               b = first + 8'((j / w) % nchr);
               if (nbytes >= 0 && pushed >= nbytes) return;
               e = {32'(cnt), 8'(l), (p == l - 1), b};
               case (which)
                  0:       q_a.push_back(e);
                  1:       q_b.push_back(e);
                  default: q_c.push_back(e);
               endcase
               pushed++;
            end
            cnt++;
         end
      end
   endtask

   task automatic sb_check(input string name, input logic [48:0] act, input int which);
      logic [48:0] e;
      int sz;
      sz = (which == 0) ? q_a.size() : (which == 1) ? q_b.size() : q_c.size();
      if (sz == 0) begin
         n_vec++;
         n_err++;
         $display("FAIL %s: unexpected byte %0h, want none", name, act);
      end else begin
         case (which)
            0:       e = q_a.pop_front();
            1:       e = q_b.pop_front();
            default: e = q_c.pop_front();
         endcase
         check(name, 64'(act), 64'(e));
      end
   endtask

   always @(negedge clk) begin
      if (reset_n && bus_a.byte_valid && bus_a.byte_ready) begin
         $display("a: byte=%h last=%b len=%0d cnt=%0d", bus_a.byte_out, bus_a.byte_last,
                  bus_a.cand_len, bus_a.cand_count);
         sb_check("sb_a", {bus_a.cand_count, bus_a.cand_len, bus_a.byte_last, bus_a.byte_out}, 0);
      end
   end

   always @(negedge clk) begin
      if (reset_n && bus_b.byte_valid && bus_b.byte_ready) begin
         $display("b: byte=%h last=%b len=%0d cnt=%0d", bus_b.byte_out, bus_b.byte_last,
                  bus_b.cand_len, bus_b.cand_count);
         sb_check("sb_b", {bus_b.cand_count, bus_b.cand_len, bus_b.byte_last, bus_b.byte_out}, 1);
      end
   end

   always @(negedge clk) begin
      if (reset_n && bus_c.byte_valid && bus_c.byte_ready) begin
         $display("c: byte=%h last=%b len=%0d cnt=%0d", bus_c.byte_out, bus_c.byte_last,
                  bus_c.cand_len, bus_c.cand_count);
         sb_check("sb_c", {bus_c.cand_count, bus_c.cand_len, bus_c.byte_last, bus_c.byte_out}, 2);
      end
   end

   initial begin
      reset_n = 1'b0;
      start_a = 1'b0; stop_a = 1'b0; init_a = 8'd1;
      start_b = 1'b0; stop_b = 1'b0; init_b = 8'd0;
      start_c = 1'b0; stop_c = 1'b0; init_c = 8'd1;
      bus_a.byte_ready = 1'b1;
      bus_b.byte_ready = 1'b1;
      bus_c.byte_ready = 1'b1;
      #2;
      check("rst_valid", bus_a.byte_valid, 1'b0);
      check("rst_busy", busy_a, 1'b0);
      check("rst_exh", exh_a, 1'b0);
      check("rst_out", {bus_a.byte_out, bus_a.cand_len, bus_a.cand_count}, 48'd0);
      tick();
      tick();
      reset_n = 1'b1;
      tick();

      // Full enumeration a..c, MAX_LEN=2, with a stall on the 'b' of "ab"
      push_seq(0, 2, 3, 8'h61, 1, -1);
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      for (int k = 0; k < 200 && !(bus_a.byte_valid && bus_a.cand_count == 32'd4 &&
                                   bus_a.byte_out == 8'h62); k++) tick();
      check("wait_ab_b", bus_a.byte_valid && bus_a.byte_out == 8'h62, 1'b1);
      bus_a.byte_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         tick();
         check("stall_hold", {bus_a.byte_valid, bus_a.byte_last, bus_a.byte_out}, {2'b11, 8'h62});
      end
      bus_a.byte_ready = 1'b1;
      for (int k = 0; k < 200 && !(bus_a.byte_valid && bus_a.cand_count == 32'd11 &&
                                   bus_a.byte_last); k++) tick();
      check("wait_cc_last", bus_a.byte_valid && bus_a.byte_last, 1'b1);
      tick();
      check("adv_not_exh", {busy_a, bus_a.byte_valid, exh_a}, 3'b100);
      tick();
      check("done_exh", {busy_a, bus_a.byte_valid, exh_a}, 3'b001);
      check("sb_a_empty1", q_a.size(), 0);

      // Restart from DONE, stop while "ac" second byte is presented
      push_seq(0, 2, 3, 8'h61, 1, 8);
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      check("restart_exh_clr", exh_a, 1'b0);
      for (int k = 0; k < 200 && !(bus_a.byte_valid && bus_a.cand_count == 32'd5 &&
                                   bus_a.byte_out == 8'h63); k++) tick();
      check("wait_ac_c", bus_a.byte_valid && bus_a.byte_out == 8'h63, 1'b1);
      bus_a.byte_ready = 1'b0;
      stop_a = 1'b1;
      tick();
      stop_a = 1'b0;
      check("stop_idle", {bus_a.byte_valid, busy_a}, 2'b00);
      check("stop_cnt_hold", bus_a.cand_count, 32'd5);
      check("sb_a_empty2", q_a.size(), 0);
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      check("restart_first", {bus_a.byte_valid, bus_a.byte_out, bus_a.cand_len, bus_a.cand_count},
            {1'b1, 8'h61, 8'd1, 32'd0});

      // init_len clamping on the a..z, MAX_LEN=8 instance
      push_seq(1, 8, 26, 8'h61, 0, 30);
      init_b = 8'd0;
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      for (int k = 0; k < 300 && q_b.size() != 0; k++) tick();
      check("drain_b0", q_b.size(), 0);
      bus_b.byte_ready = 1'b0;
      stop_b = 1'b1;
      tick();
      stop_b = 1'b0;
      check("b0_stopped", {busy_b, bus_b.cand_count}, {1'b0, 32'd27});

      push_seq(1, 8, 26, 8'h61, 9, 8);
      init_b = 8'd9;
      bus_b.byte_ready = 1'b1;
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      check("b9_len", bus_b.cand_len, 8'd8);
      for (int k = 0; k < 100 && q_b.size() != 0; k++) tick();
      check("drain_b9", q_b.size(), 0);
      bus_b.byte_ready = 1'b0;
      stop_b = 1'b1;
      tick();
      stop_b = 1'b0;
      check("b9_stopped", busy_b, 1'b0);

      // Single-character range x..x, MAX_LEN=3, run twice
      for (int r = 0; r < 2; r++) begin
         push_seq(2, 3, 1, 8'h78, 1, -1);
         start_c = 1'b1;
         tick();
         start_c = 1'b0;
         check("c_start_exh_clr", exh_c, 1'b0);
         for (int k = 0; k < 50 && !exh_c; k++) tick();
         check("c_exh", {exh_c, busy_c}, 2'b10);
         check("c_last_cnt", {bus_c.cand_count, bus_c.cand_len}, {32'd2, 8'd3});
         check("sb_c_empty", q_c.size(), 0);
      end

      // Asynchronous reset between edges while u_a streams and u_c sits in DONE
      #3;
      reset_n = 1'b0;
      #1;
      check("arst_a", {bus_a.byte_valid, busy_a, bus_a.byte_out, bus_a.cand_len}, 18'd0);
      check("arst_c", {exh_c, bus_c.cand_count, bus_c.cand_len}, 41'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      start_a = 1'b1;
      stop_a = 1'b1;
      tick();
      start_a = 1'b0;
      stop_a = 1'b0;
      check("start_stop_idle", {busy_a, bus_a.byte_valid}, 2'b00);
      tick();
      check("start_stop_idle2", busy_a, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
